// File: rtl/chiplet_types_pkg.sv
// -----------------------------------------------------------------------------
// chiplet_types_pkg
//  Shared chiplet link types: flit layout, packet-length width, the header
//  length decoder, and the TX arbiter state encoding.
// -----------------------------------------------------------------------------
package chiplet_types_pkg;

   localparam int PKT_LENGTH_WIDTH = 4;
   localparam int FLIT_PAYLOAD_W   = 28;

   // The length field is meaningful only on the header (first) beat of a packet.
   typedef struct packed {
      logic [PKT_LENGTH_WIDTH-1:0] pkt_len;
      logic [FLIT_PAYLOAD_W-1:0]   payload;
   } flit_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_arb_state_e;

   // Number of flits in the packet announced by a header flit.
   function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input flit_t hdr);
      return hdr.pkt_len;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//  Combinational rotating-priority picker. Searches req starting at ptr,
//  wrapping modulo N, and returns the first set index.
//  Ports:
//   req   in  N          request vector
//   ptr   in  clog2(N)   index with highest priority
//   idx   out clog2(N)   winning index (0 when nothing found)
//   found out 1          at least one request set
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);
   localparam int IW = $clog2(N);

   always_comb begin
      int j;
      j     = 0;
      idx   = '0;
      found = 1'b0;
      // Walk from the lowest priority upward so the closest-to-ptr hit wins last.
      for (int k = N-1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            idx   = IW'(j);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/socetlib_counter.sv
// -----------------------------------------------------------------------------
// socetlib_counter
//  Rollover counter: counts enabled events 0 .. overflow_val-1, then wraps.
//  Ports:
//   clk           in  1      clock
//   n_rst         in  1      asynchronous active-low reset
//   clear         in  1      synchronous clear (priority over count_enable)
//   count_enable  in  1      increment this cycle
//   overflow_val  in  NBITS  terminal count (number of states)
//   count_out     out NBITS  current count
//   overflow_flag out 1      count_out is the last value before wrap
// -----------------------------------------------------------------------------
module socetlib_counter #(
   parameter int NBITS = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [NBITS-1:0] overflow_val,
   output logic [NBITS-1:0] count_out,
   output logic             overflow_flag
);
   logic [NBITS-1:0] r_count;

   assign count_out     = r_count;
   assign overflow_flag = (r_count == (overflow_val - NBITS'(1)));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)              r_count <= '0;
      else if (clear)          r_count <= '0;
      else if (count_enable)   r_count <= overflow_flag ? '0 : r_count + NBITS'(1);
   end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tx_pkt_arbiter
//  Packet-level round-robin arbiter for the endpoint TX injection port. The
//  winner keeps the port until the last flit of its packet is accepted; packet
//  length is decoded from the header flit.
//  Optional: `define TX_ARB_WATCHDOG_EN adds a stall watchdog that abandons a
//  packet whose source stops presenting flits for STALL_TIMEOUT cycles.
//  Ports:
//   clk        in  1            clock
//   n_rst      in  1            asynchronous active-low reset
//   req_valid  in  NREQ         requester i presents a flit
//   req_flit   in  NREQ x flit  flit of each requester
//   req_pop    out NREQ         one-hot: flit of requester i consumed
//   out_valid  out 1            flit valid toward switch
//   out_flit   out flit         flit toward switch (0 when idle)
//   out_ready  in  1            switch accepts flit
//   busy       out 1            packet in progress
//   stall_err  out 1            sticky watchdog error (0 without watchdog)
// -----------------------------------------------------------------------------
module tx_pkt_arbiter
   import chiplet_types_pkg::*;
#(
   parameter int NREQ          = 3,
   parameter int STALL_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NREQ-1:0]     req_valid,
   input  flit_t [NREQ-1:0]    req_flit,
   output logic [NREQ-1:0]     req_pop,
   output logic                out_valid,
   output flit_t               out_flit,
   input  logic                out_ready,
   output logic                busy,
   output logic                stall_err
);
   localparam int GW = $clog2(NREQ);

   tx_arb_state_e               r_state, w_state_nxt;
   logic [GW-1:0]               r_grant, r_rr_ptr, w_pick_idx, w_grant_inc;
   logic                        w_found, w_sel_valid, w_accept, w_hdr_beat;
   logic                        w_last, w_done, w_arb, w_stall_abort;
   logic [PKT_LENGTH_WIDTH-1:0] r_pkt_len, w_count, w_hdr_len, w_eff_len;

   rr_picker #(.N(NREQ)) u_rr_picker (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .idx   (w_pick_idx),
      .found (w_found)
   );

   assign w_sel_valid = req_valid[r_grant];
   assign busy        = (r_state == SEND);
   assign out_valid   = busy & w_sel_valid;
   assign out_flit    = busy ? req_flit[r_grant] : '0;
   assign w_accept    = out_valid & out_ready;
   assign w_arb       = (r_state == IDLE) & w_found;

   always_comb begin
      req_pop = '0;
      for (int i = 0; i < NREQ; i++) req_pop[i] = w_accept & (r_grant == GW'(i));
   end

   // On the header beat the stored length is stale, so use the live decode.
   // A zero-length header still carries one flit.
   assign w_hdr_beat = (w_count == '0);
   assign w_hdr_len  = expected_num_flits(out_flit);
   assign w_eff_len  = w_hdr_beat ? ((w_hdr_len == '0) ? PKT_LENGTH_WIDTH'(1) : w_hdr_len)
                                  : r_pkt_len;
   assign w_done     = w_accept & w_last;

   assign w_grant_inc = (r_grant == GW'(NREQ-1)) ? '0 : r_grant + GW'(1);

   socetlib_counter #(.NBITS(PKT_LENGTH_WIDTH)) u_flit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_arb),
      .count_enable  (w_accept),
      .overflow_val  (w_eff_len),
      .count_out     (w_count),
      .overflow_flag (w_last)
   );

   // FSM
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_found) w_state_nxt = SEND;
         SEND:    if (w_done | w_stall_abort) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant, round-robin pointer and latched packet length
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_pkt_len <= '0;
      end else begin
         if (w_arb)                             r_grant   <= w_pick_idx;
         if (w_accept & w_hdr_beat)             r_pkt_len <= w_eff_len;
         // Pointer moves past the requester just served (or just abandoned).
         if (busy & (w_done | w_stall_abort))   r_rr_ptr  <= w_grant_inc;
      end
   end

`ifdef TX_ARB_WATCHDOG_EN
   localparam int SW = $clog2(STALL_TIMEOUT) + 1;

   logic [SW-1:0] r_stall_cnt;
   logic          r_stall_err;
   logic          w_stalled;

   // Only an absent source counts as a stall; backpressure from the switch does not.
   assign w_stalled     = busy & ~w_sel_valid;
   assign w_stall_abort = w_stalled & (r_stall_cnt == SW'(STALL_TIMEOUT-1));
   assign stall_err     = r_stall_err;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_stall_cnt <= '0;
         r_stall_err <= 1'b0;
      end else begin
         if (!w_stalled || w_stall_abort) r_stall_cnt <= '0;
         else                             r_stall_cnt <= r_stall_cnt + SW'(1);
         if (w_stall_abort)               r_stall_err <= 1'b1;
      end
   end
`else
   assign w_stall_abort = 1'b0;
   assign stall_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_pkt_arbiter
//  Self-checking bench for tx_pkt_arbiter (NREQ=3). Sources are per-requester
//  flit queues; every flit expected on the output is pushed to a scoreboard in
//  the order the round-robin should serve it and popped when the DUT pops.
//  The watchdog sequence runs only when TX_ARB_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_tx_pkt_arbiter;
   import chiplet_types_pkg::*;

   logic         clk, n_rst, out_ready, out_valid, busy, stall_err;
   logic [2:0]   req_valid, req_pop;
   flit_t [2:0]  req_flit;
   flit_t        out_flit;

   tx_pkt_arbiter #(.NREQ(3), .STALL_TIMEOUT(8)) dut (
      .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_flit(req_flit),
      .req_pop(req_pop), .out_valid(out_valid), .out_flit(out_flit),
      .out_ready(out_ready), .busy(busy), .stall_err(stall_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] src; flit_t flit; } exp_t;
   typedef struct { int len [3]; int ord [3]; int npk; int span; } vec_t;

   flit_t      src_q [3][$];
   exp_t       exp_q [$];
   logic [2:0] hold;
   vec_t       vt [6];

   int checks = 0, failures = 0, cyc = 0, n_pops = 0, last_pop_cyc = 0;
   int pkt_id = 0, R, S, p0;
   logic [2:0] s_pop;
   logic       s_busy, s_valid, s_err;
   flit_t      s_flit;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = (src_q[i].size() != 0) && !hold[i];
         req_flit[i]  = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
   endtask

   // hdr: header length field; nexp: how many leading beats the scoreboard expects
   task automatic add_pkt(input int src, input int hdr, input int nexp);
      flit_t f;
      exp_t  e;
      int    eff;
      eff = (hdr == 0) ? 1 : hdr;
      for (int b = 0; b < eff; b++) begin
         f.pkt_len = (b == 0) ? 4'(hdr) : 4'hF;
         f.payload = {4'(src), 8'(pkt_id), 8'(b), 8'hA5};
         src_q[src].push_back(f);
         if (b < nexp) begin
            e.src = 2'(src); e.flit = f;
            exp_q.push_back(e);
         end
      end
      pkt_id++;
      drive();
   endtask

   task automatic mon();
      exp_t e;
      s_pop = req_pop; s_busy = busy; s_valid = out_valid; s_err = stall_err; s_flit = out_flit;
      if (!n_rst) return;
      if (out_valid) begin
         if (exp_q.size() == 0) chk(1'b0, "unexpected_valid", out_flit, 0);
         else chk(out_flit == exp_q[0].flit, "out_flit", out_flit, exp_q[0].flit);
      end
      if (req_pop != 0) begin
         if (exp_q.size() == 0) chk(1'b0, "unexpected_pop", req_pop, 0);
         else begin
            e = exp_q.pop_front();
            chk(req_pop == (3'b001 << e.src), "req_pop", req_pop, 3'b001 << e.src);
            last_pop_cyc = cyc;
            n_pops++;
         end
      end
   endtask

   // Sample at negedge, then let the source retire what was popped at posedge.
   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 3; i++)
         if (s_pop[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      do begin step(); n++; end
      while (!(exp_q.size() == 0 && !s_busy) && n < max);
      chk(exp_q.size() == 0 && !s_busy, "drain", exp_q.size(), 0);
   endtask

   task automatic wait_pops(input int target, input int max);
      int n;
      n = 0;
      while (n_pops - p0 < target && n < max) begin step(); n++; end
      chk(n_pops - p0 == target, "pop_wait", n_pops - p0, target);
   endtask

   task automatic set_vec(input int k, input int l0, input int l1, input int l2,
                          input int o0, input int o1, input int o2, input int npk, input int span);
      vt[k].len[0] = l0; vt[k].len[1] = l1; vt[k].len[2] = l2;
      vt[k].ord[0] = o0; vt[k].ord[1] = o1; vt[k].ord[2] = o2;
      vt[k].npk = npk;   vt[k].span = span;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1);
   end

   initial begin
      // lens (-1 = no packet), expected serve order, packets, last-pop cycle offset
      set_vec(0, -1,  4, -1,   1, 0, 0,  1,  4);  // single 4-flit source
      set_vec(1,  2,  1,  3,   2, 0, 1,  3,  8);  // rr starts at 2
      set_vec(2,  0, -1,  2,   2, 0, 0,  2,  4);  // zero-length header = 1 flit
      set_vec(3, 15,  1, -1,   1, 0, 0,  2, 17);  // maximum length
      set_vec(4,  1, -1,  1,   2, 0, 0,  2,  3);
      set_vec(5, -1,  3, -1,   1, 0, 0,  1,  3);

      n_rst = 1'b0; out_ready = 1'b1; hold = '0;
      drive();

      // Reset with all sources requesting; then 0,1,2,0 of 1-flit packets.
      add_pkt(0, 1, 1); add_pkt(1, 1, 1); add_pkt(2, 1, 1); add_pkt(0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk({s_pop, s_valid, s_busy, s_err, s_flit} == '0, "reset_outputs",
             {s_pop, s_valid, s_busy, s_err, s_flit}, 0);
      end
      n_rst = 1'b1;
      R = cyc;
      step();
      chk(s_pop == 3'b000 && !s_busy, "release_idle", {s_busy, s_pop}, 0);
      step();
      chk(s_pop == 3'b001, "first_pop", s_pop, 3'b001);
      wait_idle(60);
      chk(last_pop_cyc - R == 7, "rr_bubble_span", last_pop_cyc - R, 7);

      // Table-driven simultaneous-request vectors
      for (int v = 0; v < 6; v++) begin
         S = cyc;
         for (int k = 0; k < vt[v].npk; k++) begin
            int s;
            s = vt[v].ord[k];
            add_pkt(s, vt[v].len[s], (vt[v].len[s] == 0) ? 1 : vt[v].len[s]);
         end
         wait_idle(100);
         chk(last_pop_cyc - S == vt[v].span, "vec_span", last_pop_cyc - S, vt[v].span);
      end

      // out_ready toggling during a 3-flit packet from source 2
      S = cyc; p0 = n_pops;
      add_pkt(2, 3, 3);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
         out_ready = (k % 2 == 0);
         step();
      end
      out_ready = 1'b1;
      wait_idle(20);
      chk(n_pops - p0 == 3, "toggle_pops", n_pops - p0, 3);
      chk(last_pop_cyc - S == 6, "toggle_span", last_pop_cyc - S, 6);

      // Granted source 0 pauses 5 cycles mid-packet while source 1 waits
      S = cyc; p0 = n_pops;
      add_pkt(0, 4, 4); add_pkt(1, 1, 1);
      wait_pops(2, 20);
      hold[0] = 1'b1; drive();
      for (int k = 0; k < 5; k++) begin
         step();
         chk(!s_valid && s_pop == 3'b000 && s_busy, "hold_gap", {s_valid, s_pop, s_busy}, 1);
      end
      hold[0] = 1'b0; drive();
      wait_idle(40);
      chk(last_pop_cyc - S == 11, "hold_span", last_pop_cyc - S, 11);

`ifdef TX_ARB_WATCHDOG_EN
      // Source 2 granted then stalls; watchdog abandons it and serves source 0
      p0 = n_pops;
      add_pkt(2, 3, 1); add_pkt(0, 1, 1);
      wait_pops(1, 20);
      hold[2] = 1'b1; drive();
      for (int k = 0; k < 8; k++) begin
         step();
         chk(s_busy && !s_err && !s_valid, "wd_stalling", {s_busy, s_err, s_valid}, 3'b100);
      end
      step();
      chk(!s_busy && s_err, "wd_abort", {s_busy, s_err}, 2'b01);
      wait_idle(20);
      chk(s_err, "wd_sticky", s_err, 1);
      src_q[2].delete(); hold[2] = 1'b0; drive();
`endif

      // Reset mid-packet: immediate return to idle, rr pointer back to 0
      p0 = n_pops;
      add_pkt(1, 4, 4);
      wait_pops(1, 20);
      n_rst = 1'b0;
      #1;
      chk({busy, out_valid, req_pop, stall_err, out_flit} == '0, "midpkt_reset",
          {busy, out_valid, req_pop, stall_err, out_flit}, 0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) src_q[i].delete();
      drive();
      step(); step();
      n_rst = 1'b1;
      S = cyc;
      add_pkt(1, 1, 1); add_pkt(2, 1, 1);
      wait_idle(20);
      chk(last_pop_cyc - S == 3, "post_reset_span", last_pop_cyc - S, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
